alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal 8..64).
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operation request.
REQ-005 Port: in_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 Port: in_a  input  WIDTH  operand A.
REQ-007 Port: in_b  input  WIDTH  operand B.
REQ-008 Port: in_ctrl_aluop  input  3  operation select.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out_result  output  WIDTH  registered result.
REQ-012 Port: out_zero / out_neg / out_carry  output  1 each  registered flags.

Function
REQ-013 Request accepted on a rising edge where in_valid && in_ready; in_a, in_b, opcode captured there; inputs ignored otherwise.
REQ-014 Opcodes, modulo 2^WIDTH: 100 B+A; 010 A+1; 001 -A; 000 B-A; 111 pass A; 011 A*B low WIDTH bits; 101 A AND B; 110 A OR B.
REQ-015 out_carry: carry-out for 100/010; borrow (A>B unsigned) for 000; 1 for 001 iff A!=0; 0 for 011/101/110.
REQ-016 out_zero = (result==0), out_neg = result[WIDTH-1]; all flags updated at completion, except op 111 which holds all three flags at prior values.
REQ-017 FSM states IDLE, BUSY, DONE; IDLE->DONE for single-cycle ops, IDLE->BUSY for 011, BUSY->DONE after iteration count expires, DONE->IDLE on out_ready.
REQ-018 Single-cycle ops: out_valid high on the cycle after acceptance (latency 1).
REQ-019 Op 011: iterative shift-add, one multiplier bit per cycle; out_valid high WIDTH+1 cycles after acceptance.
REQ-020 out_valid, out_result and flags held stable in DONE while out_ready low.
REQ-021 DONE with out_ready high: IDLE next cycle; out_valid low, outputs retain last values; earliest next acceptance one cycle later (no same-cycle turnaround).
REQ-022 in_valid during BUSY/DONE: no effect, no queuing.
REQ-023 Edges: -0 gives 0 with zero=1; -(2^(WIDTH-1)) gives itself with neg=1; all-ones + 1 gives 0 with zero=1, carry=1.

Reset
REQ-024 rst high at a rising edge: state IDLE, iteration counter 0, out_valid 0, out_result 0, out_zero 0, out_neg 0, out_carry 0; in_ready high from next cycle.
REQ-025 Reset during BUSY or DONE aborts; no out_valid pulse for the aborted op; rst overrides simultaneous in_valid.

Configuration
REQ-026 Macro ALU_MC_MUL_EN defined: op 011 per REQ-014/019, BUSY state and counter present.
REQ-027 ALU_MC_MUL_EN undefined: no multiplier/BUSY logic; op 011 completes in 1 cycle as pass A with flags held (identical to 111).

Verification (WIDTH=32)
REQ-028 Op 100, A=0xFFFFFFFF, B=1 -> one cycle later out_valid=1, result 0, zero=1, neg=0, carry=1.
REQ-029 Op 000, A=5, B=3 -> result 0xFFFFFFFE, neg=1, carry=1; then op 111 A=7 -> result 7, flags unchanged.
REQ-030 Op 011, A=0x10000, B=0x30003 (MUL_EN) -> out_valid exactly 33 cycles after acceptance, result 0x00030000, zero=0; in_valid pulses during BUSY ignored.
REQ-031 Op 001, A=0x80000000 with out_ready low 5 cycles -> result 0x80000000, neg=1, outputs stable all 5 cycles, in_ready low until cycle after out_ready.
REQ-032 Op 011 started, rst pulsed 10 cycles in -> all outputs 0, no out_valid, in_ready high; next op 010 A=0 gives result 1.
REQ-033 MUL_EN undefined: op 011 A=9, B=4 -> out_valid after 1 cycle, result 9, flags held.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered result and zero/neg/carry flags.
// Define ALU_MC_MUL_EN to build the iterative shift-add multiplier (op 011); otherwise 011 acts as pass A.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_ctrl_aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] res_c;
  logic [WIDTH:0]   ext_c;
  logic             carry_c;
  logic             hold_flags_c;
  logic             start_mul;

  assign in_ready = (state == IDLE);

  // Single-cycle datapath; ops that hold flags (111 and, without the multiplier, 011) fall to default.
  always_comb begin
    res_c        = in_a;
    ext_c        = '0;
    carry_c      = 1'b0;
    hold_flags_c = 1'b0;
    case (in_ctrl_aluop)
      3'b100: begin
        ext_c   = {1'b0, in_b} + {1'b0, in_a};
        res_c   = ext_c[WIDTH-1:0];
        carry_c = ext_c[WIDTH];
      end
      3'b010: begin
        ext_c   = {1'b0, in_a} + (WIDTH+1)'(1);
        res_c   = ext_c[WIDTH-1:0];
        carry_c = ext_c[WIDTH];
      end
      3'b001: begin
        res_c   = -in_a;
        carry_c = |in_a;
      end
      3'b000: begin
        res_c   = in_b - in_a;
        carry_c = (in_a > in_b);
      end
      3'b101: res_c = in_a & in_b;
      3'b110: res_c = in_a | in_b;
      default: hold_flags_c = 1'b1;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  assign start_mul = (in_ctrl_aluop == 3'b011);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
`else
  assign start_mul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
`ifdef ALU_MC_MUL_EN
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_mul) begin
`ifdef ALU_MC_MUL_EN
              mcand  <= in_a;
              mplier <= in_b;
              acc    <= '0;
              count  <= CW'(WIDTH);
              state  <= BUSY;
`endif
            end else begin
              out_result <= res_c;
              if (!hold_flags_c) begin
                out_zero  <= (res_c == '0);
                out_neg   <= res_c[WIDTH-1];
                out_carry <= carry_c;
              end
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
`ifdef ALU_MC_MUL_EN
        BUSY: begin
          // One multiplier bit per cycle; the last bit's sum goes straight to the output.
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            out_result <= acc_next;
            out_zero   <= (acc_next == '0);
            out_neg    <= acc_next[WIDTH-1];
            out_carry  <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            acc <= acc_next;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32); follows ALU_MC_MUL_EN to pick multiply expectations.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_ctrl_aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_neg;
  logic         out_carry;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  alu_mc #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_ctrl_aluop (in_ctrl_aluop),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_neg       (out_neg),
    .out_carry     (out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, then count edges until out_valid (bounded). Optional junk requests while waiting.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit junk, output int latency);
    in_ctrl_aluop = op; in_a = a; in_b = b; in_valid = 1'b1;
    check("ready_at_issue", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    latency = 1;
    while (!out_valid && latency < 200) begin
      if (junk) begin
        in_valid = latency[0]; in_ctrl_aluop = 3'b100;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      latency++;
    end
    $display("op=%b a=0x%08h b=0x%08h -> result=0x%08h z=%b n=%b c=%b latency=%0d",
             op, a, b, out_result, out_zero, out_neg, out_carry, latency);
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] r, input logic [2:0] f, input int l);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(r));
    check({tag, "_flags_znc"}, 64'({out_zero, out_neg, out_carry}), 64'(f));
    check({tag, "_latency"}, 64'(lat), 64'(l));
  endtask

  task automatic consume(input string tag, input logic [W-1:0] r);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_result_kept"}, 64'(out_result), 64'(r));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_ctrl_aluop = 3'b100; in_a = 32'd1; in_b = 32'd1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'({out_zero, out_neg, out_carry}), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    run_op(3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    expect_res("add_wrap", 32'd0, 3'b101, 1);
    consume("add_wrap", 32'd0);

    run_op(3'b000, 32'd5, 32'd3, 1'b0, lat);
    expect_res("sub_borrow", 32'hFFFF_FFFE, 3'b011, 1);
    consume("sub_borrow", 32'hFFFF_FFFE);

    run_op(3'b111, 32'd7, 32'd0, 1'b0, lat);
    expect_res("pass_hold", 32'd7, 3'b011, 1);
    consume("pass_hold", 32'd7);

`ifdef ALU_MC_MUL_EN
    run_op(3'b011, 32'h0001_0000, 32'h0003_0003, 1'b1, lat);
    expect_res("mul", 32'h0003_0000, 3'b000, 33);
    consume("mul", 32'h0003_0000);
`else
    run_op(3'b011, 32'h0001_0000, 32'h0003_0003, 1'b1, lat);
    expect_res("mul_off", 32'h0001_0000, 3'b011, 1);
    consume("mul_off", 32'h0001_0000);
`endif

    run_op(3'b001, 32'h8000_0000, 32'd0, 1'b0, lat);
    expect_res("neg_min", 32'h8000_0000, 3'b011, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_ctrl_aluop = 3'b010; in_a = 32'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_result", 64'(out_result), 64'h8000_0000);
      check("stall_flags", 64'({out_zero, out_neg, out_carry}), 64'd3);
      check("stall_ready", 64'(in_ready), 64'd0);
    end
    consume("neg_min", 32'h8000_0000);

    run_op(3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, lat);
    expect_res("and", 32'h00F0_1234, 3'b000, 1);
    consume("and", 32'h00F0_1234);

    run_op(3'b110, 32'h8000_0000, 32'd1, 1'b0, lat);
    expect_res("or", 32'h8000_0001, 3'b010, 1);
    consume("or", 32'h8000_0001);

    run_op(3'b001, 32'd0, 32'd9, 1'b0, lat);
    expect_res("neg_zero", 32'd0, 3'b100, 1);
    consume("neg_zero", 32'd0);

    run_op(3'b010, 32'hFFFF_FFFF, 32'd0, 1'b0, lat);
    expect_res("inc_wrap", 32'd0, 3'b101, 1);
    consume("inc_wrap", 32'd0);

    run_op(3'b100, 32'd3, 32'd4, 1'b0, lat);
    expect_res("add_small", 32'd7, 3'b000, 1);
    consume("add_small", 32'd7);

    run_op(3'b000, 32'd3, 32'd3, 1'b0, lat);
    expect_res("sub_equal", 32'd0, 3'b100, 1);
    consume("sub_equal", 32'd0);

    // Start a multiply and reset it part-way, with a request presented on the reset edge.
    in_ctrl_aluop = 3'b011; in_a = 32'h0001_0000; in_b = 32'h0003_0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
`ifdef ALU_MC_MUL_EN
      check("abort_no_valid", 64'(out_valid), 64'd0);
`endif
    end
    rst = 1'b1; in_valid = 1'b1; in_ctrl_aluop = 3'b100;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(out_result), 64'd0);
    check("abort_flags", 64'({out_zero, out_neg, out_carry}), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    $display("reset abort: out_valid=%b result=0x%08h in_ready=%b", out_valid, out_result, in_ready);

    run_op(3'b010, 32'd0, 32'd0, 1'b0, lat);
    expect_res("inc_after_rst", 32'd1, 3'b000, 1);
    consume("inc_after_rst", 32'd1);

    run_op(3'b000, 32'd5, 32'd3, 1'b0, lat);
    expect_res("sub_again", 32'hFFFF_FFFE, 3'b011, 1);
    consume("sub_again", 32'hFFFF_FFFE);

`ifdef ALU_MC_MUL_EN
    run_op(3'b011, 32'd9, 32'd4, 1'b0, lat);
    expect_res("mul_9x4", 32'd36, 3'b000, 33);
    consume("mul_9x4", 32'd36);
`else
    run_op(3'b011, 32'd9, 32'd4, 1'b0, lat);
    expect_res("mul_off_9", 32'd9, 3'b011, 1);
    consume("mul_off_9", 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
